// File: rtl/memsplit_dma.sv
// memsplit_dma: single-channel MemSplit32 initiator that copies len words from src to dst.
// Optional fill mode (write fill_data_i len times, no reads) is built with MEMSPLIT_DMA_FILL_EN.
module memsplit_dma #(
   parameter int unsigned LEN_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [31:0]      src_addr_i,
   input  logic [31:0]      dst_addr_i,
   input  logic [LEN_W-1:0] len_i,
   input  logic             fill_i,
   input  logic [31:0]      fill_data_i,
   output logic             bus_req_o,
   output logic             bus_we_o,
   output logic [31:0]      bus_addr_o,
   output logic [31:0]      bus_wdata_o,
   input  logic             bus_ack_i,
   input  logic             bus_resp_i,
   input  logic [31:0]      bus_rdata_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [LEN_W-1:0] words_left_o
);

   localparam logic [2:0] StIdle   = 3'd0;
   localparam logic [2:0] StRdReq  = 3'd1;
   localparam logic [2:0] StRdWait = 3'd2;
   localparam logic [2:0] StWrReq  = 3'd3;
   localparam logic [2:0] StFin    = 3'd4;

   localparam logic [LEN_W-1:0] CntOne = LEN_W'(1);

   logic [2:0]       r_state, w_state_d;
   // Word addresses: 30-bit arithmetic gives the mod 2**32 byte-address wrap for free.
   logic [29:0]      r_src, w_src_d;
   logic [29:0]      r_dst, w_dst_d;
   logic [LEN_W-1:0] r_cnt, w_cnt_d;
   logic             r_req, w_req_d;
   logic             r_we, w_we_d;
   logic [31:0]      r_addr, w_addr_d;
   logic [31:0]      r_wdata, w_wdata_d;
   logic             w_fill;
   logic             w_unused_addr;

   assign w_unused_addr = ^{src_addr_i[1:0], dst_addr_i[1:0]};

`ifdef MEMSPLIT_DMA_FILL_EN
   logic r_fill, w_fill_d;
   assign w_fill = r_fill;
`else
   logic w_unused_fill;
   assign w_fill        = 1'b0;
   assign w_unused_fill = ^{fill_i, fill_data_i};
`endif

   always_comb begin
      w_state_d = r_state;
      w_src_d   = r_src;
      w_dst_d   = r_dst;
      w_cnt_d   = r_cnt;
      w_req_d   = r_req;
      w_we_d    = r_we;
      w_addr_d  = r_addr;
      w_wdata_d = r_wdata;
`ifdef MEMSPLIT_DMA_FILL_EN
      w_fill_d  = r_fill;
`endif
      unique case (r_state)
         StIdle: begin
            if (start_i) begin
               w_src_d = src_addr_i[31:2];
               w_dst_d = dst_addr_i[31:2];
               w_cnt_d = len_i;
`ifdef MEMSPLIT_DMA_FILL_EN
               w_fill_d = fill_i;
`endif
               if (len_i == '0) begin
                  w_state_d = StFin;
`ifdef MEMSPLIT_DMA_FILL_EN
               end else if (fill_i) begin
                  w_state_d = StWrReq;
                  w_req_d   = 1'b1;
                  w_we_d    = 1'b1;
                  w_addr_d  = {dst_addr_i[31:2], 2'b00};
                  w_wdata_d = fill_data_i;
`endif
               end else begin
                  w_state_d = StRdReq;
                  w_req_d   = 1'b1;
                  w_we_d    = 1'b0;
                  w_addr_d  = {src_addr_i[31:2], 2'b00};
               end
            end
         end
         StRdReq: begin
            if (bus_ack_i) begin
               w_state_d = StRdWait;
               w_src_d   = r_src + 30'd1;
               w_req_d   = 1'b0;
            end
         end
         StRdWait: begin
            if (bus_resp_i) begin
               w_state_d = StWrReq;
               w_req_d   = 1'b1;
               w_we_d    = 1'b1;
               w_addr_d  = {r_dst, 2'b00};
               w_wdata_d = bus_rdata_i;
            end
         end
         StWrReq: begin
            if (bus_ack_i) begin
               w_dst_d = r_dst + 30'd1;
               w_cnt_d = r_cnt - CntOne;
               if (r_cnt == CntOne) begin
                  w_state_d = StFin;
                  w_req_d   = 1'b0;
                  w_we_d    = 1'b0;
               end else if (w_fill) begin
                  // Fill keeps the same pattern in wdata and only advances the address.
                  w_addr_d = {r_dst + 30'd1, 2'b00};
               end else begin
                  w_state_d = StRdReq;
                  w_we_d    = 1'b0;
                  w_addr_d  = {r_src, 2'b00};
               end
            end
         end
         StFin: begin
            w_state_d = StIdle;
         end
         default: begin
            w_state_d = StIdle;
            w_req_d   = 1'b0;
            w_we_d    = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= StIdle;
         r_src   <= '0;
         r_dst   <= '0;
         r_cnt   <= '0;
         r_req   <= 1'b0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
`ifdef MEMSPLIT_DMA_FILL_EN
         r_fill  <= 1'b0;
`endif
      end else begin
         r_state <= w_state_d;
         r_src   <= w_src_d;
         r_dst   <= w_dst_d;
         r_cnt   <= w_cnt_d;
         r_req   <= w_req_d;
         r_we    <= w_we_d;
         r_addr  <= w_addr_d;
         r_wdata <= w_wdata_d;
`ifdef MEMSPLIT_DMA_FILL_EN
         r_fill  <= w_fill_d;
`endif
      end
   end

   assign bus_req_o    = r_req;
   assign bus_we_o     = r_we;
   assign bus_addr_o   = r_addr;
   assign bus_wdata_o  = r_wdata;
   assign busy_o       = (r_state != StIdle);
   assign done_o       = (r_state == StFin);
   assign words_left_o = r_cnt;

endmodule

// File: tb/tb_memsplit_dma.sv
// tb_memsplit_dma: scoreboard bench; expected bus transactions and done pulses are queued
// by the stimulus and popped by a negedge monitor.
`timescale 1ns/1ps
module tb_memsplit_dma;

   localparam int unsigned LEN_W = 16;

   typedef struct {
      int          cyc;   // -1: cycle not checked
      int          kind;  // 0 read, 1 write, 2 done
      logic [31:0] addr;
      logic [31:0] data;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [31:0]      src, dst, fill_data;
   logic [LEN_W-1:0] len;
   logic             fill;
   logic             bus_req, bus_we, bus_ack, bus_resp;
   logic [31:0]      bus_addr, bus_wdata, bus_rdata;
   logic             busy, done;
   logic [LEN_W-1:0] words_left;

   int   cyc = 0;
   int   checks = 0;
   int   fails = 0;
   exp_t q[$];
   exp_t mon_e;

   int          stall_req = 0;
   int          stall_used = 0;
   logic        s_resp = 1'b0;
   logic        stray_resp = 1'b0;
   logic [31:0] s_rdata = 32'h0;
   logic        w_stall;

   always #5 clk = ~clk;

   memsplit_dma #(.LEN_W(LEN_W)) u_dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .start_i      (start),
      .src_addr_i   (src),
      .dst_addr_i   (dst),
      .len_i        (len),
      .fill_i       (fill),
      .fill_data_i  (fill_data),
      .bus_req_o    (bus_req),
      .bus_we_o     (bus_we),
      .bus_addr_o   (bus_addr),
      .bus_wdata_o  (bus_wdata),
      .bus_ack_i    (bus_ack),
      .bus_resp_i   (bus_resp),
      .bus_rdata_i  (bus_rdata),
      .busy_o       (busy),
      .done_o       (done),
      .words_left_o (words_left)
   );

   // Slave: combinational ack (optionally stalled on a read of 0x104), resp one cycle later.
   assign w_stall   = !bus_we && (bus_addr == 32'h104) && (stall_used < stall_req);
   assign bus_ack   = bus_req && !w_stall;
   assign bus_resp  = s_resp | stray_resp;
   assign bus_rdata = s_rdata;

   always @(posedge clk) begin
      s_resp  <= bus_req && bus_ack && !bus_we;
      s_rdata <= bus_addr ^ 32'h5A5A_0000;
      if (bus_req && w_stall) stall_used <= stall_used + 1;
      cyc <= cyc + 1;
   end

   always @(negedge clk) begin
      if (!rst && bus_req && bus_ack) begin
         checks++;
         if (q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_txn actual we=%0b addr=%08h wdata=%08h cyc=%0d required none",
                     bus_we, bus_addr, bus_wdata, cyc);
         end else begin
            mon_e = q.pop_front();
            if (mon_e.kind != int'(bus_we) || mon_e.addr != bus_addr ||
                (bus_we && mon_e.data != bus_wdata) || (mon_e.cyc >= 0 && mon_e.cyc != cyc)) begin
               fails++;
               $display("FAIL bus_txn actual kind=%0d addr=%08h data=%08h cyc=%0d required kind=%0d addr=%08h data=%08h cyc=%0d",
                        int'(bus_we), bus_addr, bus_wdata, cyc,
                        mon_e.kind, mon_e.addr, mon_e.data, mon_e.cyc);
            end
         end
      end
      if (!rst && done) begin
         checks++;
         if (q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_done actual cyc=%0d required none", cyc);
         end else begin
            mon_e = q.pop_front();
            if (mon_e.kind != 2 || (mon_e.cyc >= 0 && mon_e.cyc != cyc)) begin
               fails++;
               $display("FAIL done_pulse actual kind=2 cyc=%0d required kind=%0d cyc=%0d",
                        cyc, mon_e.kind, mon_e.cyc);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%08h required=%08h", name, act, exp);
      end
   endtask

   task automatic push(input int c, input int k, input logic [31:0] a, input logic [31:0] d);
      exp_t e;
      e.cyc  = c;
      e.kind = k;
      e.addr = a;
      e.data = d;
      q.push_back(e);
   endtask

   // Copy timing with ack=req and resp+1: read at n+1+3i, write at n+3+3i, done at n+1+3*len.
   task automatic push_copy(input int n, input logic [31:0] s, input logic [31:0] d,
                            input int l);
      logic [31:0] a;
      for (int i = 0; i < l; i++) begin
         a = s + 32'(4 * i);
         push(n + 1 + 3 * i, 0, a, 32'h0);
         push(n + 3 + 3 * i, 1, d + 32'(4 * i), a ^ 32'h5A5A_0000);
      end
      push(n + 1 + 3 * l, 2, 32'h0, 32'h0);
   endtask

   task automatic start_xfer(input logic [31:0] s, input logic [31:0] d,
                             input logic [LEN_W-1:0] l, input logic f,
                             input logic [31:0] fd, output int n);
      @(posedge clk);
      #1;
      src       = s;
      dst       = d;
      len       = l;
      fill      = f;
      fill_data = fd;
      start     = 1'b1;
      n         = cyc;
   endtask

   task automatic release_start();
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_drain(input string name, input int budget);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (!busy && q.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      checks++;
      if (!ok) begin
         fails++;
         $display("FAIL %s_drain actual pending=%0d busy=%0b required pending=0 busy=0",
                  name, q.size(), busy);
      end
      q.delete();
      repeat (3) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, n2;
      bit found;
      rst = 1'b1; start = 1'b0; src = '0; dst = '0; len = '0;
      fill = 1'b0; fill_data = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_req", 32'(bus_req), 32'h0);
      chk("rst_we", 32'(bus_we), 32'h0);
      chk("rst_addr", bus_addr, 32'h0);
      chk("rst_wdata", bus_wdata, 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_done", 32'(done), 32'h0);
      chk("rst_words_left", 32'(words_left), 32'h0);
      @(posedge clk);
      #1 rst = 1'b0;

      // Basic copy, hand-computed schedule.
      start_xfer(32'h100, 32'h200, 16'd3, 1'b0, 32'h0, n);
      push(n + 1, 0, 32'h0000_0100, 32'h0);
      push(n + 3, 1, 32'h0000_0200, 32'h5A5A_0100);
      push(n + 4, 0, 32'h0000_0104, 32'h0);
      push(n + 6, 1, 32'h0000_0204, 32'h5A5A_0104);
      push(n + 7, 0, 32'h0000_0108, 32'h0);
      push(n + 9, 1, 32'h0000_0208, 32'h5A5A_0108);
      push(n + 10, 2, 32'h0, 32'h0);
      release_start();
      @(negedge clk);
      chk("copy_busy_n1", 32'(busy), 32'h1);
      chk("copy_req_n1", 32'(bus_req), 32'h1);
      chk("copy_left_n1", 32'(words_left), 32'h3);
      repeat (3) @(negedge clk);
      chk("copy_left_n4", 32'(words_left), 32'h2);
      wait_drain("copy", 60);

      // Stall on the second read.
      stall_req = 5;
      start_xfer(32'h100, 32'h300, 16'd2, 1'b0, 32'h0, n);
      push(-1, 0, 32'h100, 32'h0);
      push(-1, 1, 32'h300, 32'h5A5A_0100);
      push(-1, 0, 32'h104, 32'h0);
      push(-1, 1, 32'h304, 32'h5A5A_0104);
      push(-1, 2, 32'h0, 32'h0);
      release_start();
      found = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus_req && !bus_we && bus_addr == 32'h104) begin
            found = 1'b1;
            break;
         end
      end
      chk("stall_seen", 32'(found), 32'h1);
      chk("stall_left", 32'(words_left), 32'h1);
      for (int i = 0; i < 5; i++) begin
         chk("stall_req", 32'(bus_req), 32'h1);
         chk("stall_we", 32'(bus_we), 32'h0);
         chk("stall_addr", bus_addr, 32'h104);
         if (i < 4) @(negedge clk);
      end
      wait_drain("stall", 60);

      // Zero length.
      start_xfer(32'h700, 32'h780, 16'd0, 1'b0, 32'h0, n);
      push(n + 1, 2, 32'h0, 32'h0);
      release_start();
      @(negedge clk);
      chk("zero_busy_n1", 32'(busy), 32'h1);
      @(negedge clk);
      chk("zero_busy_n2", 32'(busy), 32'h0);
      wait_drain("zero", 10);

      // Start while busy is dropped.
      start_xfer(32'h400, 32'h500, 16'd4, 1'b0, 32'h0, n);
      push_copy(n, 32'h400, 32'h500, 4);
      release_start();
      repeat (3) @(posedge clk);
      start_xfer(32'h900, 32'h990, 16'd1, 1'b0, 32'h0, n2);
      release_start();
      wait_drain("ignored_start", 80);

      // Source address wrap.
      start_xfer(32'hFFFF_FFF8, 32'h1000, 16'd3, 1'b0, 32'h0, n);
      push(n + 1, 0, 32'hFFFF_FFF8, 32'h0);
      push(n + 3, 1, 32'h0000_1000, 32'hA5A5_FFF8);
      push(n + 4, 0, 32'hFFFF_FFFC, 32'h0);
      push(n + 6, 1, 32'h0000_1004, 32'hA5A5_FFFC);
      push(n + 7, 0, 32'h0000_0000, 32'h0);
      push(n + 9, 1, 32'h0000_1008, 32'h5A5A_0000);
      push(n + 10, 2, 32'h0, 32'h0);
      release_start();
      wait_drain("wrap", 60);

      // Reset while waiting for the read response; a stray resp afterwards is ignored.
      start_xfer(32'h100, 32'h600, 16'd2, 1'b0, 32'h0, n);
      push(n + 1, 0, 32'h100, 32'h0);
      release_start();
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_mid_req", 32'(bus_req), 32'h0);
      chk("rst_mid_busy", 32'(busy), 32'h0);
      @(posedge clk);
      #1 stray_resp = 1'b1;
      @(posedge clk);
      #1 stray_resp = 1'b0;
      repeat (4) @(negedge clk);
      chk("stray_busy", 32'(busy), 32'h0);
      chk("stray_req", 32'(bus_req), 32'h0);
      wait_drain("rst_mid", 10);

      // Fill mode (normal copy when the fill path is not built).
      start_xfer(32'h800, 32'h40, 16'd4, 1'b1, 32'hDEAD_BEEF, n);
`ifdef MEMSPLIT_DMA_FILL_EN
      push(n + 1, 1, 32'h40, 32'hDEAD_BEEF);
      push(n + 2, 1, 32'h44, 32'hDEAD_BEEF);
      push(n + 3, 1, 32'h48, 32'hDEAD_BEEF);
      push(n + 4, 1, 32'h4C, 32'hDEAD_BEEF);
      push(n + 5, 2, 32'h0, 32'h0);
`else
      push_copy(n, 32'h800, 32'h40, 4);
`endif
      release_start();
      wait_drain("fill", 80);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule

// File: doc/memsplit_dma.md
# memsplit_dma

Single-channel word-copy engine that acts as an initiator (master) on the MemSplit32 bus. Given a source address, destination address and word count, it reads each word from the source and writes it to the destination, one transaction at a time. It sits inside a sigma tile next to the core, driving a MemSplit32 port toward the tile interconnect, and raises a completion IRQ line for the tile's interrupt enable logic.

## Interface
Parameters:
- LEN_W, 16, width of the word-count input; max transfer is 2**LEN_W-1 words.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  one-cycle start strobe; ignored while busy_o=1.
- src_addr_i  in  32  source byte address, sampled on accepted start; bits [1:0] ignored.
- dst_addr_i  in  32  destination byte address, sampled on accepted start; bits [1:0] ignored.
- len_i  in  LEN_W  number of 32-bit words, sampled on accepted start.
- fill_i  in  1  fill mode select, sampled on accepted start. Only meaningful with the fill macro; see Configuration.
- fill_data_i  in  32  fill pattern, sampled on accepted start.
- bus  MemSplit32.Master  -  initiator side. Uses req, we, addr, wdata, ack, resp, rdata.
- busy_o  out  1  transfer in progress.
- done_o  out  1  one-cycle pulse on completion.
- words_left_o  out  LEN_W  words remaining.

## Operation
- FSM states are IDLE, RD_REQ, RD_WAIT, WR_REQ and FIN.
- IDLE: start_i=1 latches the inputs into src, dst, cnt and mode.
  - cnt=0 goes to FIN.
  - Otherwise goes to RD_REQ, or to WR_REQ in fill mode.
- RD_REQ: drive req=1, we=0, addr={src[31:2],2'b00}.
  - Hold all request fields stable until ack=1.
  - On ack, go to RD_WAIT and set src+=4.
- RD_WAIT: req=0. On resp=1, latch rdata into the data register and go to WR_REQ.
- WR_REQ: drive req=1, we=1, addr={dst[31:2],2'b00}, wdata=data register.
  - On ack: dst+=4, cnt-=1.
  - If the new cnt is 0, go to FIN; otherwise go to RD_REQ, or stay in WR_REQ in fill mode.
  - Writes expect no resp.
- FIN: done_o=1 for one cycle, then go to IDLE.
- Address arithmetic is mod 2**32: 32'hFFFF_FFFC + 4 wraps to 0 silently.
- resp=1 in any state other than RD_WAIT is ignored.
- start_i while busy_o=1 is dropped. It is not queued.
- Exactly one outstanding transaction at a time; no pipelining.

## Timing
- Reset values: bus.req=0, bus.we=0, bus.addr=0, bus.wdata=0, busy_o=0, done_o=0, words_left_o=0, FSM=IDLE.
- Reset mid-transfer returns to IDLE on the next edge with req=0. A late read resp after reset is ignored.
- Start accepted at cycle N:
  - busy_o=1 and the first req are both asserted from cycle N+1.
  - All bus outputs are registered.
- With a slave that acks combinationally (ack=req) and returns resp one cycle later, each copied word takes 3 cycles:
  - read req+ack at k;
  - resp at k+1;
  - write req+ack at k+2;
  - next read at k+3.
- done_o pulses the cycle after the final write ack. busy_o falls in the cycle after done_o.
- len=0: done_o at N+1, busy_o high for that cycle only, no bus traffic.
- words_left_o updates the cycle after each write ack.
- Slave stall (ack=0): the request is held indefinitely. There is no timeout.

## Configuration
- Macro: `MEMSPLIT_DMA_FILL_EN`.
- When defined: fill_i=1 at start skips all reads. The block issues len back-to-back writes of fill_data_i, one per cycle with a combinational-ack slave.
- When undefined: fill_i and fill_data_i are ignored, the fill path is not synthesized, and every transfer is a copy.

## Test plan
- Copy: src=0x100, dst=0x200, len=3, slave ack=req with resp+1 cycle.
  - 3 reads at 0x100/0x104/0x108 and 3 writes at 0x200/0x204/0x208 with matching data.
  - done_o 10 cycles after start.
- Stall: slave holds ack=0 for 5 cycles on the 2nd read.
  - addr=0x104 and we=0 stay stable throughout the stall.
  - Transfer then completes correctly.
- Zero/ignored start: len=0 gives done_o at N+1 with no req. A second start_i during a len=4 transfer is ignored and the original completes.
- Wrap: src=0xFFFF_FFF8, len=3 reads 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- Reset mid-op: rst_i during RD_WAIT.
  - Next cycle: req=0 and busy_o=0.
  - A stray resp after reset causes no write.
- Fill (macro defined): fill_i=1, fill_data_i=0xDEADBEEF, dst=0x40, len=4.
  - 4 consecutive write cycles at 0x40..0x4C, zero reads.
  - With the macro undefined, the same stimulus performs a normal copy.
